// File: rtl/fetch_seq.sv
// Fetch sequencer: drives next_pc, issues imem req/ack fetches and hands
// words to decode over valid/ready, with redirect, halt and timeout handling.
module fetch_seq #(
   parameter logic [15:0] RESET_PC   = 16'h0000,
   parameter logic [15:0] PC_STEP    = 16'd1,
   parameter int          WAIT_LIMIT = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] current_pc,
   output logic [15:0] next_pc,
   output logic        imem_req,
   output logic [15:0] imem_addr,
   input  logic        imem_ack,
   input  logic [15:0] imem_rdata,
   input  logic        br_valid,
   input  logic [15:0] br_target,
   input  logic        halt,
   output logic        inst_valid,
   output logic [15:0] inst,
   output logic [15:0] inst_pc,
   input  logic        inst_ready,
   output logic        fetch_err
);

   localparam int CW = $clog2(WAIT_LIMIT + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_LIMIT - 1);

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      DRAIN,
      HOLD,
      HALTED,
      ERROR
   } state_t;

   state_t        state;
   logic [CW-1:0] wait_cnt;
   logic [15:0]   redir;

   assign imem_req  = (state == FETCH) || (state == DRAIN);
   assign imem_addr = current_pc;

   // PC register reloads every cycle, so holding means echoing current_pc
   always_comb begin
      next_pc = current_pc;
      unique case (state)
         IDLE: next_pc = RESET_PC;
         FETCH: begin
            if (imem_ack)
               next_pc = br_valid ? br_target : current_pc + PC_STEP;
         end
         DRAIN: begin
            if (imem_ack)
               next_pc = br_valid ? br_target : redir;
         end
         HOLD: begin
            if (br_valid)
               next_pc = br_target;
         end
         HALTED: begin
            if (br_valid)
               next_pc = br_target;
         end
         ERROR: next_pc = current_pc;
         default: next_pc = current_pc;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         inst_valid <= 1'b0;
         inst       <= 16'h0000;
         inst_pc    <= 16'h0000;
         fetch_err  <= 1'b0;
         wait_cnt   <= '0;
         redir      <= 16'h0000;
      end else begin
         unique case (state)
            IDLE: state <= halt ? HALTED : FETCH;
            FETCH: begin
               if (imem_ack) begin
                  wait_cnt <= '0;
                  if (!br_valid) begin
                     inst       <= imem_rdata;
                     inst_pc    <= current_pc;
                     inst_valid <= 1'b1;
                     state      <= HOLD;
                  end
               end else if (wait_cnt == CNT_LAST) begin
                  fetch_err <= 1'b1;
                  state     <= ERROR;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
                  if (br_valid) begin
                     redir <= br_target;
                     state <= DRAIN;
                  end
               end
            end
            DRAIN: begin
               if (imem_ack) begin
                  wait_cnt <= '0;
                  state    <= FETCH;
               end else if (wait_cnt == CNT_LAST) begin
                  fetch_err <= 1'b1;
                  state     <= ERROR;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
                  if (br_valid)
                     redir <= br_target;
               end
            end
            HOLD: begin
               if (br_valid) begin
                  inst_valid <= 1'b0;
                  state      <= FETCH;
               end else if (inst_ready) begin
                  inst_valid <= 1'b0;
                  state      <= halt ? HALTED : FETCH;
               end
            end
            HALTED: begin
               if (!halt)
                  state <= FETCH;
            end
            ERROR: state <= ERROR;
            default: state <= ERROR;
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_seq.sv
// Directed bench for fetch_seq: per-cycle vector table plus hand-written
// reset-in-drain and timeout sequences. The bench plays the PC register.
module tb_fetch_seq;

   logic        clk;
   logic        rst_n;
   logic [15:0] pc;
   logic [15:0] next_pc;
   logic        imem_req;
   logic [15:0] imem_addr;
   logic        imem_ack;
   logic [15:0] imem_rdata;
   logic        br_valid;
   logic [15:0] br_target;
   logic        halt;
   logic        inst_valid;
   logic [15:0] inst;
   logic [15:0] inst_pc;
   logic        inst_ready;
   logic        fetch_err;

   int checks;
   int fails;

   fetch_seq #(
      .WAIT_LIMIT(4)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .current_pc (pc),
      .next_pc    (next_pc),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_ack   (imem_ack),
      .imem_rdata (imem_rdata),
      .br_valid   (br_valid),
      .br_target  (br_target),
      .halt       (halt),
      .inst_valid (inst_valid),
      .inst       (inst),
      .inst_pc    (inst_pc),
      .inst_ready (inst_ready),
      .fetch_err  (fetch_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) pc <= next_pc;

   // memory word is a fixed scramble of its address
   assign imem_rdata = pc ^ 16'h5A5A;

   typedef struct {
      logic        ack;
      logic        br;
      logic [15:0] tgt;
      logic        hlt;
      logic        rdy;
      logic        req;
      logic [15:0] addr;
      logic [15:0] npc;
      logic        vld;
      logic [15:0] ipc;
   } vec_t;

   vec_t tv[29];

   function automatic vec_t mk(
      input logic a, input logic b, input logic [15:0] t,
      input logic h, input logic r, input logic q,
      input logic [15:0] ad, input logic [15:0] np,
      input logic v, input logic [15:0] ip);
      vec_t x;
      x.ack = a; x.br = b; x.tgt = t; x.hlt = h; x.rdy = r;
      x.req = q; x.addr = ad; x.npc = np; x.vld = v; x.ipc = ip;
      return x;
   endfunction

   task automatic chk(input string nm, input logic [15:0] act,
                      input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp,
                  $time);
      end
   endtask

   task automatic drive(input logic a, input logic b, input logic [15:0] t,
                        input logic h, input logic r);
      imem_ack   = a;
      br_valid   = b;
      br_target  = t;
      halt       = h;
      inst_ready = r;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not end");
      $fatal(1, "watchdog");
   end

   initial begin
      checks = 0;
      fails  = 0;
      //            ack br tgt      h  r  req addr     npc      v  ipc
      tv[0]  = mk(0, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0);
      tv[1]  = mk(1, 0, 16'h0000, 0, 1, 1, 16'h0000, 16'h0001, 0, 16'h0);
      tv[2]  = mk(1, 0, 16'h0000, 0, 1, 0, 16'h0001, 16'h0001, 1, 16'h0);
      tv[3]  = mk(1, 0, 16'h0000, 0, 1, 1, 16'h0001, 16'h0002, 0, 16'h0);
      tv[4]  = mk(1, 0, 16'h0000, 0, 1, 0, 16'h0002, 16'h0002, 1, 16'h1);
      tv[5]  = mk(1, 0, 16'h0000, 0, 1, 1, 16'h0002, 16'h0003, 0, 16'h0);
      tv[6]  = mk(1, 0, 16'h0000, 0, 1, 0, 16'h0003, 16'h0003, 1, 16'h2);
      tv[7]  = mk(0, 1, 16'h0040, 0, 1, 1, 16'h0003, 16'h0003, 0, 16'h0);
      tv[8]  = mk(0, 0, 16'h0000, 0, 1, 1, 16'h0003, 16'h0003, 0, 16'h0);
      tv[9]  = mk(0, 0, 16'h0000, 0, 1, 1, 16'h0003, 16'h0003, 0, 16'h0);
      tv[10] = mk(1, 0, 16'h0000, 0, 1, 1, 16'h0003, 16'h0040, 0, 16'h0);
      tv[11] = mk(1, 1, 16'h1234, 0, 1, 1, 16'h0040, 16'h1234, 0, 16'h0);
      tv[12] = mk(1, 0, 16'h0000, 0, 0, 1, 16'h1234, 16'h1235, 0, 16'h0);
      tv[13] = mk(0, 0, 16'h0000, 0, 0, 0, 16'h1235, 16'h1235, 1, 16'h1234);
      tv[14] = mk(0, 1, 16'hFFFF, 0, 0, 0, 16'h1235, 16'hFFFF, 1, 16'h1234);
      tv[15] = mk(1, 0, 16'h0000, 0, 0, 1, 16'hFFFF, 16'h0000, 0, 16'h0);
      tv[16] = mk(0, 0, 16'h0000, 1, 1, 0, 16'h0000, 16'h0000, 1, 16'hFFFF);
      tv[17] = mk(0, 0, 16'h0000, 1, 0, 0, 16'h0000, 16'h0000, 0, 16'h0);
      tv[18] = mk(0, 1, 16'h0100, 1, 0, 0, 16'h0000, 16'h0100, 0, 16'h0);
      tv[19] = mk(0, 0, 16'h0000, 0, 0, 0, 16'h0100, 16'h0100, 0, 16'h0);
      tv[20] = mk(0, 0, 16'h0000, 0, 0, 1, 16'h0100, 16'h0100, 0, 16'h0);
      tv[21] = mk(1, 0, 16'h0000, 0, 0, 1, 16'h0100, 16'h0101, 0, 16'h0);
      tv[22] = mk(0, 0, 16'h0000, 0, 1, 0, 16'h0101, 16'h0101, 1, 16'h0100);
      tv[23] = mk(0, 1, 16'h0200, 0, 0, 1, 16'h0101, 16'h0101, 0, 16'h0);
      tv[24] = mk(0, 1, 16'h0300, 0, 0, 1, 16'h0101, 16'h0101, 0, 16'h0);
      tv[25] = mk(1, 0, 16'h0000, 0, 0, 1, 16'h0101, 16'h0300, 0, 16'h0);
      tv[26] = mk(0, 1, 16'h0400, 0, 0, 1, 16'h0300, 16'h0300, 0, 16'h0);
      tv[27] = mk(1, 1, 16'h0500, 0, 0, 1, 16'h0300, 16'h0500, 0, 16'h0);
      tv[28] = mk(0, 0, 16'h0000, 0, 0, 1, 16'h0500, 16'h0500, 0, 16'h0);

      rst_n = 1'b0;
      drive(0, 0, 16'h0000, 0, 0);
      @(posedge clk);
      @(posedge clk);
      #1;
      chk("rst_valid", {15'd0, inst_valid}, 16'h0000);
      chk("rst_inst", inst, 16'h0000);
      chk("rst_inst_pc", inst_pc, 16'h0000);
      chk("rst_err", {15'd0, fetch_err}, 16'h0000);
      chk("rst_req", {15'd0, imem_req}, 16'h0000);
      chk("rst_next_pc", next_pc, 16'h0000);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 29; i++) begin
         drive(tv[i].ack, tv[i].br, tv[i].tgt, tv[i].hlt, tv[i].rdy);
         #2;
         chk($sformatf("v%0d_req", i), {15'd0, imem_req},
             {15'd0, tv[i].req});
         chk($sformatf("v%0d_addr", i), imem_addr, tv[i].addr);
         chk($sformatf("v%0d_next_pc", i), next_pc, tv[i].npc);
         chk($sformatf("v%0d_valid", i), {15'd0, inst_valid},
             {15'd0, tv[i].vld});
         if (tv[i].vld) begin
            chk($sformatf("v%0d_inst_pc", i), inst_pc, tv[i].ipc);
            chk($sformatf("v%0d_inst", i), inst, tv[i].ipc ^ 16'h5A5A);
         end
         @(negedge clk);
      end

      // redirect without ack enters DRAIN, then reset lands mid-drain
      drive(0, 1, 16'h0600, 0, 0);
      #2;
      chk("drn_next_pc", next_pc, 16'h0500);
      @(negedge clk);
      drive(0, 0, 16'h0000, 0, 0);
      #2;
      chk("drn_req", {15'd0, imem_req}, 16'h0001);
      chk("drn_valid", {15'd0, inst_valid}, 16'h0000);
      #1;
      rst_n = 1'b0;
      #1;
      chk("arst_req", {15'd0, imem_req}, 16'h0000);
      chk("arst_next_pc", next_pc, 16'h0000);
      chk("arst_inst_pc", inst_pc, 16'h0000);
      chk("arst_inst", inst, 16'h0000);
      imem_ack = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #2;
      chk("idle_req", {15'd0, imem_req}, 16'h0000);
      chk("idle_next_pc", next_pc, 16'h0000);
      @(negedge clk);
      chk("idle_ack_ignored", {15'd0, inst_valid}, 16'h0000);

      // timeout: four unacknowledged request cycles, then ERROR
      for (int k = 0; k < 4; k++) begin
         drive(0, 0, 16'h0000, 0, 0);
         #2;
         chk($sformatf("to%0d_req", k), {15'd0, imem_req}, 16'h0001);
         chk($sformatf("to%0d_addr", k), imem_addr, 16'h0000);
         chk($sformatf("to%0d_err", k), {15'd0, fetch_err}, 16'h0000);
         @(negedge clk);
      end
      drive(1, 1, 16'h7777, 0, 1);
      #2;
      chk("err_req", {15'd0, imem_req}, 16'h0000);
      chk("err_flag", {15'd0, fetch_err}, 16'h0001);
      chk("err_next_pc", next_pc, 16'h0000);
      chk("err_valid", {15'd0, inst_valid}, 16'h0000);
      @(negedge clk);
      #2;
      chk("err_sticky", {15'd0, fetch_err}, 16'h0001);
      chk("err_req2", {15'd0, imem_req}, 16'h0000);
      rst_n = 1'b0;
      #1;
      chk("err_cleared", {15'd0, fetch_err}, 16'h0000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule
